ucie_ctl_adapter_rdi_tx: RTL and testbench

Adapter-side RDI transmit stage, directly upstream of the PHY data-transfer path. Buffers flits from the protocol layer in a small FIFO and drives lp_irdy / lp_valid / lp_data toward the PHY, advancing on pl_trdy. Gates transmission on pl_state_sts == Active. Flushes buffered flits on LinkError or an explicit flush request.

---
 rtl/ucie_ctl_adapter_pkg.sv | 28 ++
 rtl/ucie_ctl_sync_fifo.sv | 53 +++++
 rtl/ucie_ctl_adapter_rdi_tx.sv | 111 +++++++++++
 tb/tb_ucie_ctl_adapter_rdi_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_adapter_pkg.sv
// Shared types for the adapter RDI path: PHY state encodings, TX FSM states and counter widths.
package ucie_ctl_adapter_pkg;

  typedef enum logic [3:0] {
    RESET        = 4'b0000,
    ACTIVE       = 4'b0001,
    ACTIVE_PMNAK = 4'b0011,
    L1           = 4'b0100,
    L2           = 4'b1000,
    LINKRESET    = 4'b1001,
    LINKERROR    = 4'b1010,
    RETRAIN      = 4'b1011,
    DISABLED     = 4'b1100
  } rdi_state_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } tx_fsm_e;

  localparam int DROP_CNT_W = 16;

  function automatic logic flush_req(input rdi_state_e sts, input logic flush);
    return flush || (sts == LINKERROR);
  endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// Generic synchronous FIFO: registered count, 1-cycle write-to-head latency, head reads 0 when empty.
// Push is ignored when full and pop when empty, so callers cannot corrupt the pointers.
module ucie_ctl_sync_fifo
  import ucie_ctl_adapter_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/ucie_ctl_adapter_rdi_tx.sv
// RDI TX stage: buffers protocol flits and presents them to the PHY one cycle after push while in RUN; ready drops when full or flushing.
// Optional macro UCIE_CTL_RDI_TX_STATS_EN builds the o_tx_flit_cnt transfer counter (port tied to 0 otherwise).
module ucie_ctl_adapter_rdi_tx
  import ucie_ctl_adapter_pkg::*;
#(
  parameter int NBYTES = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pr_valid,
  input  logic [NBYTES*8-1:0]     i_pr_data,
  output logic                    o_pr_ready,
  input  logic [3:0]              i_rdi_pl_state_sts,
  input  logic                    i_rdi_pl_trdy,
  input  logic                    i_flush,
  output logic                    o_rdi_lp_irdy,
  output logic                    o_rdi_lp_valid,
  output logic [NBYTES*8-1:0]     o_rdi_lp_data,
  output logic [$clog2(DEPTH):0]  o_fifo_count,
  output logic [DROP_CNT_W-1:0]   o_drop_cnt,
  output logic [31:0]             o_tx_flit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_fsm_e                state_q, state_d;
  rdi_state_e             sts;
  logic                   rdy_en_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   go_flush, xfer, drop;

  assign sts      = rdi_state_e'(i_rdi_pl_state_sts);
  assign go_flush = flush_req(sts, i_flush);

  // rdy_en_q keeps ready low while reset is held and for the release cycle.
  assign o_pr_ready     = rdy_en_q && !fifo_full && (state_q != FLUSH) && !i_flush;
  assign o_rdi_lp_valid = (state_q == RUN) && !fifo_empty;
  assign o_rdi_lp_irdy  = o_rdi_lp_valid;

  assign xfer      = o_rdi_lp_valid && i_rdi_pl_trdy;
  assign drop      = (state_q == FLUSH) && !fifo_empty;
  assign fifo_push = i_pr_valid && o_pr_ready;
  assign fifo_pop  = xfer || drop;

  ucie_ctl_sync_fifo #(
    .WIDTH (NBYTES*8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_data  (i_pr_data),
    .o_data  (o_rdi_lp_data),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (go_flush)           state_d = FLUSH;
        else if (sts == ACTIVE) state_d = RUN;
      end
      RUN: begin
        if (go_flush)           state_d = FLUSH;
        else if (sts != ACTIVE) state_d = IDLE;
      end
      FLUSH: begin
        if (fifo_empty || (fifo_count == CW'(1) && drop)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rdy_en_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_fifo_count = fifo_count;
  assign o_drop_cnt   = drop_cnt_q;

`ifdef UCIE_CTL_RDI_TX_STATS_EN
  logic [31:0] tx_flit_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     tx_flit_cnt_q <= '0;
    else if (xfer) tx_flit_cnt_q <= tx_flit_cnt_q + 32'd1;
  end

  assign o_tx_flit_cnt = tx_flit_cnt_q;
`else
  assign o_tx_flit_cnt = '0;
`endif

endmodule

// File: tb/tb_ucie_ctl_adapter_rdi_tx.sv
// Directed bench for the RDI TX stage with a data scoreboard fed at push and drained at PHY transfer.
module tb_ucie_ctl_adapter_rdi_tx;
  import ucie_ctl_adapter_pkg::*;

  localparam int NBYTES = 8;
  localparam int DEPTH  = 4;
  localparam int DW     = NBYTES * 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pr_valid = 1'b0;
  logic [DW-1:0] pr_data = '0;
  logic          pr_ready;
  logic [3:0]    sts = RESET;
  logic          trdy = 1'b0;
  logic          flush = 1'b0;
  logic          lp_irdy, lp_valid;
  logic [DW-1:0] lp_data;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic [31:0]   tx_cnt;

  logic [DW-1:0] exp_q [$];
  int            n_assert = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  ucie_ctl_adapter_rdi_tx #(.NBYTES(NBYTES), .DEPTH(DEPTH)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pr_valid         (pr_valid),
    .i_pr_data          (pr_data),
    .o_pr_ready         (pr_ready),
    .i_rdi_pl_state_sts (sts),
    .i_rdi_pl_trdy      (trdy),
    .i_flush            (flush),
    .o_rdi_lp_irdy      (lp_irdy),
    .o_rdi_lp_valid     (lp_valid),
    .o_rdi_lp_data      (lp_data),
    .o_fifo_count       (count),
    .o_drop_cnt         (drop_cnt),
    .o_tx_flit_cnt      (tx_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes at the falling edge, then advances to just past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (lp_valid && trdy) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else                   chk("lp_data", lp_data, exp_q.pop_front());
    end
    if (pr_valid && pr_ready) exp_q.push_back(pr_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 12 && count != '0; n++) tick();
    #1;
    chk("drain_count", count, 0);
    chk("drain_sb_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, pr_ready, 0);
    chk({tag, "_valid"}, lp_valid, 0);
    chk({tag, "_irdy"},  lp_irdy, 0);
    chk({tag, "_data"},  lp_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_drop"},  drop_cnt, 0);
    chk({tag, "_txcnt"}, tx_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and ready rising on the first cycle after release.
    #2;
    chk_all_zero("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    #1;
    chk("rst_release_ready", pr_ready, 1);

    // 1: streaming with trdy held high, count never exceeds 1.
    sts = ACTIVE; trdy = 1'b1; pr_valid = 1'b1; pr_data = 64'hA1;
    #1;
    chk("t1_valid_c1", lp_valid, 0);
    tick();
    for (int i = 2; i <= 4; i++) begin
      pr_data = 64'hA0 + 64'(i);
      #1;
      chk("t1_valid", lp_valid, 1);
      chk("t1_count", count, 1);
      tick();
    end
    pr_valid = 1'b0;
    #1;
    chk("t1_last_valid", lp_valid, 1);
    drain();
    chk("t1_valid_end", lp_valid, 0);

    // 2: fill to DEPTH with trdy low, fifth flit held until space opens.
    trdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      pr_valid = 1'b1;
      pr_data  = 64'hB0 + 64'(k);
      #1;
      chk("t2_ready", pr_ready, (k <= 4) ? 64'd1 : 64'd0);
      chk("t2_count", count, (k <= 4) ? 64'(k - 1) : 64'd4);
      if (k < 5) tick();
    end
    trdy = 1'b1;
    #1;
    chk("t2_full_valid", lp_valid, 1);
    chk("t2_full_ready", pr_ready, 0);
    tick();
    #1;
    chk("t2_ready_reassert", pr_ready, 1);
    chk("t2_count_after_pop", count, 3);
    tick();
    pr_valid = 1'b0;
    drain();

    // 3: leave RUN for RETRAIN, head retained and re-presented.
    trdy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      pr_valid = 1'b1;
      pr_data  = 64'hC0 + 64'(k);
      tick();
    end
    pr_valid = 1'b0;
    sts = RETRAIN;
    #1;
    chk("t3_count", count, 3);
    chk("t3_valid_exit_cycle", lp_valid, 1);
    tick();
    #1;
    chk("t3_valid_idle", lp_valid, 0);
    chk("t3_irdy_idle", lp_irdy, 0);
    chk("t3_data_held", lp_data, 64'hC1);
    trdy = 1'b1;
    tick();
    tick();
    #1;
    chk("t3_count_idle", count, 3);
    sts = ACTIVE;
    tick();
    #1;
    chk("t3_valid_rerun", lp_valid, 1);
    chk("t3_data_rerun", lp_data, 64'hC1);
    drain();

    // 4: flush together with a push; push rejected, three drops.
    trdy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      pr_valid = 1'b1;
      pr_data  = 64'hD0 + 64'(k);
      tick();
    end
    pr_data = 64'hD4;
    flush   = 1'b1;
    #1;
    chk("t4_ready_flush", pr_ready, 0);
    tick();
    flush = 1'b0; pr_valid = 1'b0;
    repeat (3) void'(exp_q.pop_front());
    #1;
    chk("t4_valid_flush", lp_valid, 0);
    chk("t4_ready_in_flush", pr_ready, 0);
    chk("t4_count_start", count, 3);
    tick();
    #1;
    chk("t4_count_1", count, 2);
    chk("t4_drop_1", drop_cnt, 1);
    tick();
    tick();
    #1;
    chk("t4_count_end", count, 0);
    chk("t4_drop_end", drop_cnt, 3);
    chk("t4_ready_idle", pr_ready, 1);
    tick();

    // 5: async reset in the middle of a LinkError flush.
    for (int k = 1; k <= 2; k++) begin
      pr_valid = 1'b1;
      pr_data  = 64'hE0 + 64'(k);
      tick();
    end
    pr_valid = 1'b0;
    sts = LINKERROR;
    tick();
    #1;
    chk("t5_count_flush", count, 2);
    chk("t5_valid_flush", lp_valid, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    exp_q.delete();
    sts = RESET;
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("t5_ready_post", pr_ready, 1);
    chk("t5_drop_post", drop_cnt, 0);
    chk("t5_count_post", count, 0);

    // 6: transfer counter, wrapping when the stats build is enabled.
    sts = ACTIVE; trdy = 1'b1;
    tick();
`ifdef UCIE_CTL_RDI_TX_STATS_EN
    force dut.tx_flit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.tx_flit_cnt_q;
`endif
    for (int k = 1; k <= 3; k++) begin
      pr_valid = 1'b1;
      pr_data  = 64'hF0 + 64'(k);
      tick();
    end
    pr_valid = 1'b0;
    drain();
`ifdef UCIE_CTL_RDI_TX_STATS_EN
    chk("t6_txcnt_wrap", tx_cnt, 1);
`else
    chk("t6_txcnt_off", tx_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
